// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM between instruction fetch and data ports.
// Optional MEM_ARB_PERF_EN adds per-port stall-cycle counters.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_type,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_type,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       if_stall_cnt,
  output logic [31:0]       d_stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic owner_d;
  logic [3:0] starve_cnt;
  logic [1:0] wait_cnt;
  logic grant_d, grant_i;
  // data has fixed priority unless fetch has lost STARVE_MAX contested rounds in a row
  always_comb begin
    grant_d = d_req && !(if_req && starve_cnt == 4'(STARVE_MAX));
    grant_i = if_req && !grant_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      if_rdata   <= '0;
      if_ack     <= 1'b0;
      d_rdata    <= '0;
      d_ack      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_type   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_d || grant_i) begin
          state    <= ISSUE;
          busy     <= 1'b1;
          owner_d  <= grant_d;
          mem_en   <= 1'b1;
          mem_we   <= grant_d && d_we;
          mem_type <= grant_d ? d_type : 3'b010;
          mem_addr <= grant_d ? d_addr : if_addr;
          if (grant_d) mem_wdata <= d_wdata;
          if (grant_i) starve_cnt <= '0;
          else if (if_req && starve_cnt != 4'hf) starve_cnt <= starve_cnt + 4'd1;
        end
        ISSUE: begin
          mem_en   <= 1'b0;
          mem_we   <= 1'b0;
          wait_cnt <= 2'(MEM_LAT - 1);
          state    <= mem_we ? RESP : WAIT;
          d_ack    <= mem_we;
        end
        WAIT: if (wait_cnt == '0) begin
          state <= RESP;
          if (owner_d) begin
            d_ack   <= 1'b1;
            d_rdata <= mem_rdata;
          end else begin
            if_ack   <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end else wait_cnt <= wait_cnt - 2'd1;
        RESP: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_stall_cnt <= '0;
      d_stall_cnt  <= '0;
    end else begin
      if_stall_cnt <= if_stall_cnt + 32'(if_req && !if_ack);
      d_stall_cnt  <= d_stall_cnt + 32'(d_req && !d_ack);
    end
  end
`endif
endmodule
